// File: rtl/rr_tag_sched.sv
// Round-robin read-request scheduler with PCIe tag pool and owner table.
// Optional per-requester outstanding cap: RR_TAG_SCHED_MAXOUT_EN.
module rr_tag_sched #(
  parameter int NREQ   = 4,
  parameter int TAGW   = 3,
  parameter int MAXOUT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   rri_valid,
  output logic [NREQ-1:0]   rri_ready,
  input  logic [64*NREQ-1:0] rri_addr,
  output logic              rro_valid,
  input  logic              rro_ready,
  output logic [63:0]       rro_addr,
  output logic [7:0]        rro_tag,
  input  logic              rc_valid,
  input  logic [7:0]        rc_tag,
  input  logic              rc_last,
  output logic              rc_owner_valid,
  output logic [2:0]        rc_owner,
  output logic [TAGW:0]     free_count,
  output logic              err_spurious
);

  localparam int NTAG = 1 << TAGW;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state_q;
  logic [NTAG-1:0] busy_q;
  logic [2:0]      owner_q [NTAG];
  logic [2:0]      last_q;
  logic [63:0]     addr_q;
  logic [TAGW-1:0] slot_q;
  logic            vld_q;
  logic            own_vld_q;
  logic [2:0]      own_q;
  logic [TAGW:0]   free_q;
  logic            err_q;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] cand;
  logic            hi_any;
  logic [2:0]      hi_idx;
  logic [2:0]      lo_idx;
  logic [2:0]      gnt_idx;
  logic            grant;
  logic [63:0]     gaddr;
  logic [TAGW-1:0] slot;

  logic [TAGW-1:0] rc_slot;
  logic            rc_hit;
  logic            do_free;
  logic            spur;

  // Search above last_q first, else wrap to the lowest candidate.
  always_comb begin
    cand   = rri_valid & elig;
    hi_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand[k]) begin
        lo_idx = 3'(k);
        if (3'(k) > last_q) begin
          hi_any = 1'b1;
          hi_idx = 3'(k);
        end
      end
    end
    gnt_idx = hi_any ? hi_idx : lo_idx;
  end

  always_comb begin
    slot = '0;
    for (int k = NTAG - 1; k >= 0; k--) begin
      if (!busy_q[k]) slot = TAGW'(k);
    end
  end

  always_comb begin
    gaddr = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_idx == 3'(k)) gaddr = rri_addr[64*k +: 64];
    end
  end

  assign grant = reset_n && (state_q == IDLE) &&
                 (|cand) && (free_q != '0);

  assign rri_ready = grant ?
    ({{(NREQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;

  assign rc_slot = rc_tag[TAGW-1:0];
  assign rc_hit  = busy_q[rc_slot] && (rc_tag[7:TAGW] == '0);
  assign do_free = rc_valid && rc_last && rc_hit;
  assign spur    = rc_valid && !rc_hit;

`ifdef RR_TAG_SCHED_MAXOUT_EN
  logic [3:0] cnt_q [NREQ];

  always_comb begin
    elig = '0;
    for (int k = 0; k < NREQ; k++) begin
      elig[k] = (cnt_q[k] != 4'(MAXOUT));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NREQ; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        cnt_q[k] <= cnt_q[k]
          + 4'(grant && (gnt_idx == 3'(k)))
          - 4'(do_free && (owner_q[rc_slot] == 3'(k)));
      end
    end
  end
`else
  logic unused_maxout;
  assign unused_maxout = (MAXOUT > 0);
  assign elig = '1;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      busy_q    <= '0;
      for (int k = 0; k < NTAG; k++) owner_q[k] <= '0;
      last_q    <= 3'(NREQ - 1);
      addr_q    <= '0;
      slot_q    <= '0;
      vld_q     <= 1'b0;
      own_vld_q <= 1'b0;
      own_q     <= '0;
      free_q    <= (TAGW+1)'(NTAG);
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (grant) begin
          state_q       <= HOLD;
          vld_q         <= 1'b1;
          addr_q        <= gaddr;
          slot_q        <= slot;
          last_q        <= gnt_idx;
        end
        HOLD: if (rro_ready) begin
          state_q <= IDLE;
          vld_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
      if (do_free) busy_q[rc_slot] <= 1'b0;
      if (grant) begin
        busy_q[slot]  <= 1'b1;
        owner_q[slot] <= gnt_idx;
      end
      free_q <= free_q - (TAGW+1)'(grant)
                       + (TAGW+1)'(do_free);
      own_vld_q <= rc_valid;
      if (rc_valid) own_q <= owner_q[rc_slot];
      if (spur) err_q <= 1'b1;
    end
  end

  assign rro_valid      = vld_q;
  assign rro_addr       = addr_q;
  assign rro_tag        = {(8-TAGW)'(0), slot_q};
  assign rc_owner_valid = own_vld_q;
  assign rc_owner       = own_q;
  assign free_count     = free_q;
  assign err_spurious   = err_q;

endmodule
